// File: rtl/dot_prod_host_if.sv
// -----------------------------------------------------------------------------
// dot_prod_host_if
//
// Stream bundle between a job source/sink and dot_prod_host.
//   in_valid / in_ready / in_a / in_b : element-pair stream into the host
//   res_valid / res_ready / res_data  : dot-product result stream out of the host
//
// Modports:
//   master : the job source/sink (drives pairs, consumes results)
//   slave  : dot_prod_host (consumes pairs, produces results)
// -----------------------------------------------------------------------------
interface dot_prod_host_if #(
  parameter int DATA_W = 27
);

  // Element-pair stream
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;

  // Result stream
  logic                     res_valid;
  logic                     res_ready;
  logic signed [63:0]       res_data;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data
  );

endinterface

// File: rtl/dot_prod_host.sv
// -----------------------------------------------------------------------------
// dot_prod_host
//
// Host-side driver for the dot-product core. A job is:
//   1. LOAD  : accept N_ELEM (a, b) pairs from the input stream and write them
//              into the core's arr_a / arr_b through the controlArr port.
//   2. FLUSH : one cycle in which the final array write is still on the bus.
//   3. RUN   : release the core (r_enable = 0) and wait for w_enable.
//   4. DONE  : hold the captured result on the result stream until consumed.
// A watchdog aborts RUN after TIMEOUT cycles and raises a sticky err flag,
// which is cleared when the next job starts.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   start                    begin a job (sampled in IDLE only)
//   io (slave)               element-pair stream in, result stream out
//   err                      sticky watchdog error
//   busy                     high whenever the FSM is not in IDLE
//   controlArr               host owns the core arrays
//   controlArrWEnable_a/_b   array write enables (always identical)
//   controlArrAddr_a/_b      array write addresses (always identical)
//   controlArrWData_a/_b     array write data, passed through unmodified
//   r_enable                 core hold/restart; core is parked while high
//   init_i, init_acc         core initial values, constant 0
//   w_enable, result         core result valid (level) and result value
//
// Every output comes straight from a register.
// -----------------------------------------------------------------------------
module dot_prod_host #(
  parameter int N_ELEM  = 1000,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 27,
  parameter int TIMEOUT = 8192
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,

  dot_prod_host_if.slave           io,

  output logic                     err,
  output logic                     busy,

  output logic                     controlArr,
  output logic                     controlArrWEnable_a,
  output logic [ADDR_W-1:0]        controlArrAddr_a,
  output logic [DATA_W-1:0]        controlArrWData_a,
  output logic                     controlArrWEnable_b,
  output logic [ADDR_W-1:0]        controlArrAddr_b,
  output logic [DATA_W-1:0]        controlArrWData_b,

  output logic                     r_enable,
  output logic [63:0]              init_i,
  output logic [63:0]              init_acc,
  input  logic                     w_enable,
  input  logic [63:0]              result
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_ELEM - 1);
  localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registered outputs (_q) with their next values (_d)
  // ---------------------------------------------------------------------------
  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   idx_q,       idx_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;

  logic                in_ready_q,  in_ready_d;
  logic                res_valid_q, res_valid_d;
  logic [63:0]         res_data_q,  res_data_d;
  logic                err_q,       err_d;
  logic                busy_q,      busy_d;
  logic                ctrl_q,      ctrl_d;
  logic                we_q,        we_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   wdata_a_q,   wdata_a_d;
  logic [DATA_W-1:0]   wdata_b_q,   wdata_b_d;
  logic                r_enable_q,  r_enable_d;

  // A beat is taken only in LOAD; in_ready is low everywhere else, but the
  // explicit state term keeps in_valid inert outside LOAD by construction.
  logic accept;
  assign accept = (state_q == S_LOAD) && io.in_valid && in_ready_q;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement so no
    // path leaves one unassigned; otherwise synthesis would infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_d       = err_q;
    ctrl_d      = ctrl_q;
    we_d        = 1'b0;           // write strobes are single-cycle pulses
    addr_d      = addr_q;
    wdata_a_d   = wdata_a_q;
    wdata_b_d   = wdata_b_q;
    r_enable_d  = r_enable_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          idx_d      = '0;
          err_d      = 1'b0;
          in_ready_d = 1'b1;
          ctrl_d     = 1'b1;
          r_enable_d = 1'b1;
        end
      end

      S_LOAD: begin
        if (accept) begin
          we_d      = 1'b1;
          addr_d    = idx_q;
          wdata_a_d = io.in_a;
          wdata_b_d = io.in_b;
          idx_d     = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d    = S_FLUSH;
            in_ready_d = 1'b0;
          end
        end
      end

      // The last write is on the bus during this cycle; hand the arrays back
      // and release the core together on the following edge.
      S_FLUSH: begin
        state_d    = S_RUN;
        ctrl_d     = 1'b0;
        r_enable_d = 1'b0;
        cnt_d      = '0;
      end

      // cnt_q counts RUN cycles from 0, so the abort lands exactly TIMEOUT
      // cycles after RUN is entered. A result arriving in the final cycle
      // still wins over the watchdog.
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (w_enable) begin
          res_data_d  = result;
          res_valid_d = 1'b1;
          r_enable_d  = 1'b1;
          state_d     = S_DONE;
        end else if (cnt_q == LAST_TICK) begin
          err_d      = 1'b1;
          r_enable_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

      S_DONE: begin
        if (io.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b0;
        res_valid_d = 1'b0;
        ctrl_d      = 1'b0;
        r_enable_d  = 1'b1;
      end
    endcase

    // busy is registered from the next state so it tracks the state register.
    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      ctrl_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_a_q   <= '0;
      wdata_b_q   <= '0;
      r_enable_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      ctrl_q      <= ctrl_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_a_q   <= wdata_a_d;
      wdata_b_q   <= wdata_b_d;
      r_enable_q  <= r_enable_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The a and b array ports share one enable/address register so
  // they can never drift apart in time.
  // ---------------------------------------------------------------------------
  assign io.in_ready          = in_ready_q;
  assign io.res_valid         = res_valid_q;
  assign io.res_data          = res_data_q;

  assign err                  = err_q;
  assign busy                 = busy_q;

  assign controlArr           = ctrl_q;
  assign controlArrWEnable_a  = we_q;
  assign controlArrWEnable_b  = we_q;
  assign controlArrAddr_a     = addr_q;
  assign controlArrAddr_b     = addr_q;
  assign controlArrWData_a    = wdata_a_q;
  assign controlArrWData_b    = wdata_b_q;

  assign r_enable             = r_enable_q;
  assign init_i               = 64'd0;
  assign init_acc             = 64'd0;

endmodule

// File: tb/tb_dot_prod_host.sv
// -----------------------------------------------------------------------------
// tb_dot_prod_host
//
// Drives randomized and directed jobs into dot_prod_host, with a behavioural
// stand-in for the dot-product core on the array/run side. Expected results
// come from plain arithmetic over the issued pairs and are queued; a monitor
// pops and compares on every result handshake.
// -----------------------------------------------------------------------------
module tb_dot_prod_host;

  localparam int N_ELEM  = 1000;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 27;
  localparam int TIMEOUT = 64;
  localparam int DEPTH   = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;

  logic              err, busy, controlArr, we_a, we_b, r_enable;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] wd_a, wd_b;
  logic [63:0]       init_i, init_acc;
  logic              w_enable = 1'b0;
  logic [63:0]       result   = 64'd0;

  dot_prod_host_if #(.DATA_W(DATA_W)) bus ();

  dot_prod_host #(
    .N_ELEM (N_ELEM),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .io                 (bus),
    .err                (err),
    .busy               (busy),
    .controlArr         (controlArr),
    .controlArrWEnable_a(we_a),
    .controlArrAddr_a   (addr_a),
    .controlArrWData_a  (wd_a),
    .controlArrWEnable_b(we_b),
    .controlArrAddr_b   (addr_b),
    .controlArrWData_b  (wd_b),
    .r_enable           (r_enable),
    .init_i             (init_i),
    .init_acc           (init_acc),
    .w_enable           (w_enable),
    .result             (result)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic finish_now();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // ---------------------------------------------------------------------------
  // Core stand-in: array storage plus a run that takes a random number of
  // cycles, then holds w_enable until r_enable rises. Arrays are filled with
  // garbage at each new job so stale contents cannot hide a missing write.
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] arr_a [0:DEPTH-1];
  logic signed [DATA_W-1:0] arr_b [0:DEPTH-1];
  int job_id   = 0;
  int seen_job = 0;
  int run_lat  = 4;
  int run_cnt  = 0;
  bit hang     = 1'b0;

  function automatic longint core_dot();
    longint s = 0;
    for (int i = 0; i < N_ELEM; i++) s += longint'(arr_a[i]) * longint'(arr_b[i]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (job_id != seen_job) begin
      seen_job <= job_id;
      run_lat  <= int'($urandom_range(2, 40));
      for (int i = 0; i < DEPTH; i++) begin
        arr_a[i] <= DATA_W'($urandom);
        arr_b[i] <= DATA_W'($urandom);
      end
    end
    if (controlArr && we_a) arr_a[addr_a] <= wd_a;
    if (controlArr && we_b) arr_b[addr_b] <= wd_b;
    if (r_enable) begin
      w_enable <= 1'b0;
      run_cnt  <= 0;
    end else if (!w_enable && !hang) begin
      if (run_cnt == run_lat) begin
        w_enable <= 1'b1;
        result   <= core_dot();
      end else begin
        run_cnt <= run_cnt + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference data for the current job and the expected-result scoreboard
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] job_a [0:DEPTH-1];
  logic [DATA_W-1:0] job_b [0:DEPTH-1];
  longint exp_q [$];

  // Write monitor: every array write must be a paired a/b write at the next
  // contiguous address carrying the issued data. Cleared whenever idle.
  int wr_cnt = 0;
  int wr_bad = 0;

  always @(negedge clk) begin
    if (!busy) begin
      wr_cnt <= 0;
      wr_bad <= 0;
    end else if (we_a || we_b) begin
      if (!(we_a && we_b && controlArr && addr_a == ADDR_W'(wr_cnt) && addr_b == addr_a &&
            wd_a == job_a[wr_cnt % DEPTH] && wd_b == job_b[wr_cnt % DEPTH]) || wr_cnt >= N_ELEM)
        wr_bad <= wr_bad + 1;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Result monitor: compare on each handshake against the oldest expectation.
  always @(negedge clk) begin
    if (bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        check("result", bus.res_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // mode 0: a = i, b = 1; mode 1: a = -1, b = 2; mode 2: random signed
  task automatic fill_job(input int mode, output longint expected);
    int va, vb;
    expected = 0;
    for (int i = 0; i < N_ELEM; i++) begin
      case (mode)
        0:       begin va = i;  vb = 1; end
        1:       begin va = -1; vb = 2; end
        default: begin
          va = int'($urandom_range(0, (1 << DATA_W) - 1)) - (1 << (DATA_W - 1));
          vb = int'($urandom_range(0, (1 << DATA_W) - 1)) - (1 << (DATA_W - 1));
        end
      endcase
      job_a[i] = DATA_W'(va);
      job_b[i] = DATA_W'(vb);
      expected += longint'(va) * longint'(vb);
    end
  endtask

  task automatic start_job();
    job_id++;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("in_ready_in_load", bus.in_ready, 1);
    check("err_cleared_on_start", err, 0);
  endtask

  task automatic feed(input int n, input bit throttle);
    int i = 0;
    int budget = 0;
    int follow_bad = 0;
    bit acc;
    while (i < n) begin
      bus.in_valid = throttle ? ((budget % 2 == 0) && ($urandom_range(0, 3) != 0)) : 1'b1;
      bus.in_a     = job_a[i];
      bus.in_b     = job_b[i];
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      cyc();
      if (we_a !== acc) follow_bad++;
      if (acc) i++;
      budget++;
      if (budget > 8 * n + 100) begin
        check("feed_timeout", 64'd0, 64'd1);
        finish_now();
      end
    end
    bus.in_valid = 1'b0;
    check("we_follows_accept", follow_bad, 0);
  endtask

  // Called in the FLUSH cycle; returns in the first RUN cycle.
  task automatic after_feed_checks();
    check("flush_last_we", we_a, 1);
    check("flush_last_addr", addr_a, N_ELEM - 1);
    check("flush_ctrl", controlArr, 1);
    check("flush_in_ready", bus.in_ready, 0);
    check("flush_r_enable", r_enable, 1);
    cyc();
    check("run_ctrl_fell", controlArr, 0);
    check("run_we", we_a, 0);
    check("run_r_enable", r_enable, 0);
    check("write_count", wr_cnt, N_ELEM);
    check("write_errors", wr_bad, 0);
  endtask

  task automatic collect(input int hold);
    int k = 0;
    int bad = 0;
    logic [63:0] captured;
    bus.res_ready = 1'b0;
    while (!bus.res_valid) begin
      cyc();
      k++;
      if (k > 200) begin
        check("result_timeout", 64'd0, 64'd1);
        finish_now();
      end
    end
    captured = bus.res_data;
    for (int j = 0; j < hold; j++) begin
      if (bus.res_data !== captured || !bus.res_valid || !r_enable || !busy) bad++;
      start = (hold >= 10 && j == hold / 2);
      cyc();
    end
    start = 1'b0;
    if (hold > 0) check("done_hold_stable", bad, 0);
    bus.res_ready = 1'b1;
    cyc();
    bus.res_ready = 1'b0;
    check("idle_res_valid", bus.res_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_in_ready", bus.in_ready, 0);
    check("idle_r_enable", r_enable, 1);
  endtask

  task automatic run_job(input int mode, input bit throttle, input int hold);
    longint e;
    fill_job(mode, e);
    start_job();
    feed(N_ELEM, throttle);
    exp_q.push_back(e);
    after_feed_checks();
    collect(hold);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    longint e;
    int k;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;

    // Reset values
    repeat (3) cyc();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_ctrl", controlArr, 0);
    check("rst_we", {we_a, we_b}, 0);
    check("rst_addr", {addr_a, addr_b}, 0);
    check("rst_wdata", {wd_a, wd_b}, 0);
    check("rst_r_enable", r_enable, 1);
    check("init_zero", init_i | init_acc, 0);
    rst = 1'b0;
    cyc();
    check("idle_after_rst", busy, 0);

    run_job(0, 1'b0, 5);    // counting ramp
    run_job(1, 1'b0, 3);    // negative values
    run_job(0, 1'b1, 0);    // throttled input
    run_job(2, 1'b0, 50);   // result backpressure with an ignored start
    repeat (2) run_job(2, 1'(int'($urandom_range(0, 1))), int'($urandom_range(0, 5)));

    // Reset in the middle of LOAD
    fill_job(0, e);
    start_job();
    feed(500, 1'b0);
    rst = 1'b1;
    cyc();
    check("midload_rst_ctrl", controlArr, 0);
    check("midload_rst_in_ready", bus.in_ready, 0);
    check("midload_rst_r_enable", r_enable, 1);
    check("midload_rst_busy", busy, 0);
    check("midload_rst_we", we_a, 0);
    start = 1'b1;           // start together with reset: reset wins
    cyc();
    check("rst_beats_start", busy, 0);
    rst   = 1'b0;
    start = 1'b0;
    cyc();
    check("idle_after_rst_start", busy, 0);
    run_job(0, 1'b0, 2);

    // Watchdog: core never reports completion
    hang = 1'b1;
    fill_job(2, e);
    start_job();
    feed(N_ELEM, 1'b0);
    after_feed_checks();
    check("run_no_err", err, 0);
    for (k = 1; k <= 200; k++) begin
      cyc();
      if (err) break;
    end
    check("watchdog_cycles", k, TIMEOUT);
    check("watchdog_idle", busy, 0);
    check("watchdog_r_enable", r_enable, 1);
    check("watchdog_no_valid", bus.res_valid, 0);
    repeat (10) cyc();
    check("err_sticky", err, 1);
    check("still_no_valid", bus.res_valid, 0);
    hang = 1'b0;
    run_job(2, 1'b0, 1);    // start clears err; normal job succeeds

    repeat (3) cyc();
    check("results_outstanding", exp_q.size(), 0);
    finish_now();
  end

  initial begin
    #1_000_000;
    check("global_timeout", 64'd0, 64'd1);
    finish_now();
  end

endmodule
